uart_packet_decoder: RTL and testbench

Receive-side framer for the host-to-board pixel link. It consumes the byte stream from the UART receiver and reassembles 24-bit packets sent MSB-first, laid out as {header 3'b101, loc[9:0], data[7:0], footer[2:0]}. It checks the header, footer and location of each packet. Good packets become a single-cycle write into image RAM. It also counts packets and errors and raises receive_done once a full image has been loaded.

---
 rtl/uart_packet_decoder.sv | 168 ++++++++++++++++
 tb/tb_uart_packet_decoder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_decoder.sv
// Reassembles 3-byte MSB-first pixel packets from the UART byte stream into RAM writes.
// Optional inter-byte timeout is enabled by defining PKT_TIMEOUT_EN.
module uart_packet_decoder #(
  parameter int unsigned NUM_WORDS   = 20,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned ERR_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 4000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             clr,
  output logic             wr_en,
  output logic [9:0]       wr_addr,
  output logic [7:0]       wr_data,
  output logic [CNT_W-1:0] count_packets,
  output logic [ERR_W-1:0] hdr_err,
  output logic [ERR_W-1:0] ftr_err,
  output logic [ERR_W-1:0] loc_err,
  output logic             receive_done
);

  localparam logic [1:0] S_B0  = 2'd0;
  localparam logic [1:0] S_B1  = 2'd1;
  localparam logic [1:0] S_B2  = 2'd2;
  localparam logic [1:0] S_CHK = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [20:0]      pkt_q, pkt_d;
  logic             wr_en_q, wr_en_d;
  logic [9:0]       wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [ERR_W-1:0] hdr_q, hdr_d, ftr_q, ftr_d, loc_q, loc_d;
  logic             done_q, done_d;
  logic             hdr_inc, ftr_inc, loc_inc, timeout;

  logic [9:0] pkt_loc;
  logic [7:0] pkt_data;
  logic [2:0] pkt_ftr, ftr_exp;

  // Header bits are checked on arrival, so only loc/data/footer are stored.
  assign pkt_loc  = pkt_q[20:11];
  assign pkt_data = pkt_q[10:3];
  assign pkt_ftr  = pkt_q[2:0];
  assign ftr_exp  = {^pkt_data, ^pkt_loc, ^{pkt_data[7:4], pkt_loc[9:5]}};
  assign cnt_inc  = cnt_q + CNT_W'(1);

`ifdef PKT_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] tmr_q;
  logic             mid_pkt;

  assign mid_pkt = (state_q == S_B1) || (state_q == S_B2);
  assign timeout = mid_pkt && !rx_valid && (tmr_q == TMR_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || clr || rx_valid || !mid_pkt) tmr_q <= '0;
    else                                    tmr_q <= tmr_q + TMR_W'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pkt_d     = pkt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    hdr_inc   = 1'b0;
    ftr_inc   = 1'b0;
    loc_inc   = 1'b0;

    case (state_q)
      S_B1: if (rx_valid) begin
        pkt_d[15:8] = rx_data;
        state_d     = S_B2;
      end
      S_B2: if (rx_valid) begin
        pkt_d[7:0] = rx_data;
        state_d    = S_CHK;
      end
      default: begin
        if (state_q == S_CHK) begin
          state_d = S_B0;
          if (pkt_ftr != ftr_exp) begin
            ftr_inc = 1'b1;
          end else if ({22'd0, pkt_loc} >= NUM_WORDS) begin
            loc_inc = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = pkt_loc;
            wr_data_d = pkt_data;
            cnt_d     = cnt_inc;
            if (cnt_inc == CNT_W'(NUM_WORDS)) done_d = 1'b1;
          end
        end
        // A byte landing in S_CHK starts the next packet rather than being lost.
        if (rx_valid) begin
          if (rx_data[7:5] == 3'b101) begin
            pkt_d[20:16] = rx_data[4:0];
            state_d      = S_B1;
          end else begin
            hdr_inc = 1'b1;
          end
        end
      end
    endcase

    if (timeout) begin
      state_d = S_B0;
      hdr_inc = 1'b1;
    end

    hdr_d = (hdr_inc && hdr_q != '1) ? hdr_q + ERR_W'(1) : hdr_q;
    ftr_d = (ftr_inc && ftr_q != '1) ? ftr_q + ERR_W'(1) : ftr_q;
    loc_d = (loc_inc && loc_q != '1) ? loc_q + ERR_W'(1) : loc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_B0;
      pkt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
      hdr_q     <= '0;
      ftr_q     <= '0;
      loc_q     <= '0;
      done_q    <= 1'b0;
    end else if (clr) begin
      state_q   <= S_B0;
      pkt_q     <= '0;
      wr_en_q   <= 1'b0;
      cnt_q     <= '0;
      hdr_q     <= '0;
      ftr_q     <= '0;
      loc_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pkt_q     <= pkt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
      hdr_q     <= hdr_d;
      ftr_q     <= ftr_d;
      loc_q     <= loc_d;
      done_q    <= done_d;
    end
  end

  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign count_packets = cnt_q;
  assign hdr_err       = hdr_q;
  assign ftr_err       = ftr_q;
  assign loc_err       = loc_q;
  assign receive_done  = done_q;

endmodule

// File: tb/tb_uart_packet_decoder.sv
// Randomized bench for uart_packet_decoder against a byte-stream parser model.
// Define PKT_TIMEOUT_EN to also exercise the inter-byte timeout.
module tb_uart_packet_decoder;
  localparam int unsigned NW = 20;
  localparam int unsigned CW = 32;
  localparam int unsigned EW = 4;
  localparam int unsigned TO = 4000;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst, rx_valid, clr;
  logic [7:0]    rx_data;
  logic          wr_en;
  logic [9:0]    wr_addr;
  logic [7:0]    wr_data;
  logic [CW-1:0] count_packets;
  logic [EW-1:0] hdr_err, ftr_err, loc_err;
  logic          receive_done;

  uart_packet_decoder #(
    .NUM_WORDS(NW), .CNT_W(CW), .ERR_W(EW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .count_packets(count_packets), .hdr_err(hdr_err), .ftr_err(ftr_err),
    .loc_err(loc_err), .receive_done(receive_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: a pure byte-stream parser, independent of cycle-level FSM details.
  typedef struct { int cyc; int addr; int data; bit done; } wr_t;
  wr_t exp_q[$];
  int          m_pos;
  logic [23:0] m_word;
  longint      m_cnt;
  int          m_hdr, m_ftr, m_loc;
  bit          m_done;
  int          m_last_addr, m_last_data;

  function automatic int sat(input int v);
    return (v < ERR_MAX) ? v + 1 : v;
  endfunction

  function automatic logic [2:0] footer_of(input logic [9:0] l, input logic [7:0] d);
    return {^d, ^l, ^{d[7:4], l[9:5]}};
  endfunction

  function automatic void model_clear();
    m_pos = 0; m_cnt = 0; m_hdr = 0; m_ftr = 0; m_loc = 0; m_done = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int sample_cyc);
    logic [9:0] l;
    logic [7:0] d;
    if (m_pos == 0) begin
      if (b[7:5] == 3'b101) begin m_word = {b, 16'h0}; m_pos = 1; end
      else m_hdr = sat(m_hdr);
    end else if (m_pos == 1) begin
      m_word[15:8] = b; m_pos = 2;
    end else begin
      m_word[7:0] = b; m_pos = 0;
      l = m_word[20:11];
      d = m_word[10:3];
      if (m_word[2:0] != footer_of(l, d)) m_ftr = sat(m_ftr);
      else if (int'(l) >= NW) m_loc = sat(m_loc);
      else begin
        m_cnt++;
        if (m_cnt == NW) m_done = 1;
        m_last_addr = int'(l);
        m_last_data = int'(d);
        exp_q.push_back('{sample_cyc + 1, int'(l), int'(d), m_done});
      end
    end
  endfunction

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) check_eq("spurious_wr", 1, 0);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        check_eq("wr_cycle", cyc, e.cyc);
        check_eq("wr_addr", wr_addr, e.addr);
        check_eq("wr_data", wr_data, e.data);
        check_eq("done_at_wr", receive_done, e.done);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    model_byte(b, cyc + 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  function automatic logic [23:0] mk_pkt(input int loc, input int data, input bit bad);
    logic [9:0] l;
    logic [7:0] d;
    logic [2:0] f;
    l = 10'(loc);
    d = 8'(data);
    f = footer_of(l, d);
    if (bad) f = f ^ (3'b001 << $urandom_range(0, 2));
    return {3'b101, l, d, f};
  endfunction

  task automatic send_pkt(input logic [23:0] w, input int max_gap);
    send(w[23:16]); idle($urandom_range(0, max_gap));
    send(w[15:8]);  idle($urandom_range(0, max_gap));
    send(w[7:0]);
  endtask

  task automatic check_state(input string tag);
    idle(4);
    check_eq({tag, "_count"}, count_packets, 64'(m_cnt));
    check_eq({tag, "_hdr"}, hdr_err, m_hdr);
    check_eq({tag, "_ftr"}, ftr_err, m_ftr);
    check_eq({tag, "_loc"}, loc_err, m_loc);
    check_eq({tag, "_done"}, receive_done, m_done);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    model_clear();
    exp_q.delete();
  endtask

  task automatic do_clr(input bit with_byte, input logic [7:0] b);
    clr = 1'b1;
    rx_valid = with_byte;
    rx_data = b;
    @(negedge clk);
    clr = 1'b0;
    rx_valid = 1'b0;
    model_clear();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; rx_valid = 1'b0; rx_data = '0;
    m_last_addr = 0; m_last_data = 0;
    @(negedge clk);
    do_reset();
    check_eq("rst_wr_en", wr_en, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_wr_data", wr_data, 0);
    check_state("rst");

    send(8'hA0); send(8'h01); send(8'hE0);
    check_state("good0");
    send(8'hA0); send(8'h2F); send(8'hF8);
    send(8'hA0); send(8'h2F); send(8'hF9);
    check_state("ftr");
    send(8'h40); send(8'hA0); send(8'h01); send(8'hE0);
    check_state("resync");
    send(8'hA0); send(8'hA0); send(8'h00);
    check_state("loc20");

    // Full image with back-to-back packets so bytes land in the check cycle.
    do_clr(1'b0, 8'h00);
    for (int l = 0; l < int'(NW); l++) send_pkt(mk_pkt(l, $urandom_range(0, 255), 0), 0);
    check_state("image");
    send_pkt(mk_pkt(3, 8'h5A, 0), 2);
    check_state("image21");
    do_clr(1'b0, 8'h00);
    check_state("clr");
    check_eq("clr_hold_addr", wr_addr, m_last_addr);
    check_eq("clr_hold_data", wr_data, m_last_data);

    do_clr(1'b1, 8'hA0);
    send(8'h01); send(8'hE0);
    check_state("clr_vs_byte");

    send(8'hA0); send(8'h01);
    idle(1);
    do_reset();
    send_pkt(mk_pkt(7, 8'hC3, 0), 1);
    check_state("midrst");

`ifdef PKT_TIMEOUT_EN
    send(8'hA0);
    idle(5000);
    m_pos = 0;
    m_hdr = sat(m_hdr);
    send_pkt(mk_pkt(0, 8'h3C, 0), 0);
    check_state("timeout");
`endif

    for (int i = 0; i < 160; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        logic [7:0] j;
        j = 8'($urandom);
        if (j[7:5] == 3'b101) j[7] = 1'b0;
        send(j);
      end else begin
        send_pkt(mk_pkt($urandom_range(0, NW + 4), $urandom_range(0, 255), r == 1), 3);
      end
      idle($urandom_range(0, 3));
      if (i % 40 == 39) check_state("rand");
    end
    check_state("final");
    idle(3);
    check_eq("pending_writes", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
